line_render_sched: RTL and testbench



---
 rtl/line_render_sched_pkg.sv | 21 ++
 rtl/line_render_sched_if.sv | 37 +++
 rtl/line_render_sched_clear_cnt.sv | 22 ++
 rtl/line_render_sched.sv | 100 ++++++++++
 tb/tb_line_render_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/line_render_sched_pkg.sv
// Shared types and constants for the ping-pong line buffer render scheduler.
package line_render_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_BG,
    ST_SPR,
    ST_DONE
  } state_e;

  localparam int DEF_LINE_WIDTH  = 256;
  localparam int DEF_CLEAR_COLOR = 0;
  localparam int TRANSPARENT_IDX = 0;

  // States in which a line start means the back bank was not finished.
  function automatic logic is_rendering(state_e s);
    return (s == ST_CLEAR) || (s == ST_BG) || (s == ST_SPR);
  endfunction

endpackage

// File: rtl/line_render_sched_if.sv
// Renderer/timing side bus of the line render scheduler.
interface line_render_sched_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  iline_start;
  logic                  ibg_wr;
  logic [ADDR_WIDTH-1:0] ibg_addr;
  logic [DATA_WIDTH-1:0] ibg_data;
  logic                  ibg_done;
  logic                  ispr_wr;
  logic [ADDR_WIDTH-1:0] ispr_addr;
  logic [DATA_WIDTH-1:0] ispr_data;
  logic                  ispr_done;
  logic                  ogrant_bg;
  logic                  ogrant_spr;
  logic                  owr;
  logic [ADDR_WIDTH-1:0] owr_addr;
  logic [DATA_WIDTH-1:0] owr_data;
  logic                  obank;
  logic                  oline_ready;
  logic                  ooverrun;

  modport master (
    output iline_start, ibg_wr, ibg_addr, ibg_data, ibg_done,
           ispr_wr, ispr_addr, ispr_data, ispr_done,
    input  ogrant_bg, ogrant_spr, owr, owr_addr, owr_data,
           obank, oline_ready, ooverrun
  );

  modport slave (
    input  iline_start, ibg_wr, ibg_addr, ibg_data, ibg_done,
           ispr_wr, ispr_addr, ispr_data, ispr_done,
    output ogrant_bg, ogrant_spr, owr, owr_addr, owr_data,
           obank, oline_ready, ooverrun
  );
endinterface

// File: rtl/line_render_sched_clear_cnt.sv
// Clear-pass address counter: restarts on start, steps while enabled, flags the last pixel.
module line_clear_cnt #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  last
);

  assign last = (count == ADDR_WIDTH'(LINE_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (start)  count <= '0;
    else if (en)     count <= last ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/line_render_sched.sv
// Per-scanline scheduler: swaps banks on line start, clears the back bank, then grants bg and sprite writers.
// Optional LINE_RENDER_SCHED_TRANSP_EN: sprite writes of colour index 0 are suppressed (transparent pixels).
module line_render_sched
  import line_render_sched_pkg::*;
#(
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int CLEAR_COLOR = DEF_CLEAR_COLOR
) (
  input logic               iclk,
  input logic               irst_n,
  line_render_sched_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] LW = (ADDR_WIDTH + 1)'(LINE_WIDTH);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  bank;
  logic                  ovr;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  bg_ok, spr_ok;

  line_clear_cnt #(.LINE_WIDTH(LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_clr (
    .clk  (iclk),
    .rst_n(irst_n),
    .start(bus.iline_start),
    .en   (state == ST_CLEAR),
    .count(clr_cnt),
    .last (clr_last)
  );

  assign bg_ok = bus.ibg_wr && ({1'b0, bus.ibg_addr} < LW);
`ifdef LINE_RENDER_SCHED_TRANSP_EN
  assign spr_ok = bus.ispr_wr && ({1'b0, bus.ispr_addr} < LW) &&
                  (bus.ispr_data != DATA_WIDTH'(TRANSPARENT_IDX));
`else
  assign spr_ok = bus.ispr_wr && ({1'b0, bus.ispr_addr} < LW);
`endif

  always_comb begin
    state_nxt = state;
    wr_d      = 1'b0;
    addr_d    = bus.ibg_addr;
    data_d    = bus.ibg_data;
    if (bus.iline_start) begin
      // Line start overrides every other event, including a same-cycle write.
      state_nxt = ST_CLEAR;
    end else begin
      case (state)
        ST_CLEAR: if (clr_last) state_nxt = ST_BG;
        ST_BG: begin
          wr_d = bg_ok;
          if (bus.ibg_done) state_nxt = ST_SPR;
        end
        ST_SPR: begin
          wr_d   = spr_ok;
          addr_d = bus.ispr_addr;
          data_d = bus.ispr_data;
          if (bus.ispr_done) state_nxt = ST_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state  <= ST_IDLE;
      bank   <= 1'b0;
      ovr    <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      if (bus.iline_start) bank <= ~bank;
      // A sprite done coinciding with line start still counts as a finished line.
      ovr    <= bus.iline_start && is_rendering(state) &&
                !(state == ST_SPR && bus.ispr_done);
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bus.ogrant_bg   = (state == ST_BG);
  assign bus.ogrant_spr  = (state == ST_SPR);
  assign bus.owr         = (state == ST_CLEAR) ? 1'b1 : wr_q;
  assign bus.owr_addr    = (state == ST_CLEAR) ? clr_cnt : addr_q;
  assign bus.owr_data    = (state == ST_CLEAR) ? DATA_WIDTH'(CLEAR_COLOR) : data_q;
  assign bus.obank       = bank;
  assign bus.oline_ready = (state == ST_DONE);
  assign bus.ooverrun    = ovr;

endmodule

// File: tb/tb_line_render_sched.sv
// Directed bench for line_render_sched: clear pass, layer grants, overrun and swap corner cases.
module tb_line_render_sched;

  logic iclk = 1'b0;
  logic irst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic exp_bank = 1'b0;

  line_render_sched_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  line_render_sched #(
    .LINE_WIDTH(256), .ADDR_WIDTH(8), .DATA_WIDTH(8), .CLEAR_COLOR(0)
  ) dut (
    .iclk  (iclk),
    .irst_n(irst_n),
    .bus   (bus)
  );

  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iline_start = 1'b0;
    bus.ibg_wr = 1'b0; bus.ibg_addr = '0; bus.ibg_data = '0; bus.ibg_done = 1'b0;
    bus.ispr_wr = 1'b0; bus.ispr_addr = '0; bus.ispr_data = '0; bus.ispr_done = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    bus.iline_start = 1'b1;
    step();
    bus.iline_start = 1'b0;
    exp_bank = ~exp_bank;
  endtask

  task automatic test_reset();
    idle_inputs();
    irst_n = 1'b0;
    step();
    checks++; if (bus.obank !== 1'b0) begin errors++; $display("FAIL reset_bank: got %b want 0", bus.obank); end
    checks++; if (bus.owr !== 1'b0) begin errors++; $display("FAIL reset_owr: got %b want 0", bus.owr); end
    checks++; if ({bus.ogrant_bg, bus.ogrant_spr} !== 2'b00) begin errors++; $display("FAIL reset_grants: got %b want 00", {bus.ogrant_bg, bus.ogrant_spr}); end
    checks++; if ({bus.oline_ready, bus.ooverrun} !== 2'b00) begin errors++; $display("FAIL reset_ready_ovr: got %b want 00", {bus.oline_ready, bus.ooverrun}); end
    irst_n = 1'b1;
    step();
    checks++; if (bus.owr !== 1'b0) begin errors++; $display("FAIL idle_owr: got %b want 0", bus.owr); end
  endtask

  task automatic test_clear();
    pulse_start();
    checks++; if (bus.obank !== 1'b1) begin errors++; $display("FAIL clear_bank: got %b want 1", bus.obank); end
    checks++; if (bus.ooverrun !== 1'b0) begin errors++; $display("FAIL clear_no_ovr: got %b want 0", bus.ooverrun); end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (bus.owr !== 1'b1 || bus.owr_addr !== 8'(i) || bus.owr_data !== 8'h00 || bus.ogrant_bg !== 1'b0) begin
        errors++;
        $display("FAIL clear_write[%0d]: got wr=%b addr=%0d data=%0h gbg=%b want wr=1 addr=%0d data=0 gbg=0",
                 i, bus.owr, bus.owr_addr, bus.owr_data, bus.ogrant_bg, i);
      end
      step();
    end
    checks++; if (bus.ogrant_bg !== 1'b1) begin errors++; $display("FAIL bg_grant_rise: got %b want 1", bus.ogrant_bg); end
    checks++; if (bus.owr !== 1'b0) begin errors++; $display("FAIL bg_idle_owr: got %b want 0", bus.owr); end
  endtask

  task automatic test_bg_write();
    bus.ibg_wr = 1'b1; bus.ibg_addr = 8'd10; bus.ibg_data = 8'h3C;
    bus.ispr_wr = 1'b1; bus.ispr_addr = 8'd20; bus.ispr_data = 8'h77;
    step();
    idle_inputs();
    checks++; if ({bus.owr, bus.owr_addr, bus.owr_data} !== {1'b1, 8'd10, 8'h3C}) begin errors++; $display("FAIL bg_write: got wr=%b addr=%0d data=%0h want 1/10/3c", bus.owr, bus.owr_addr, bus.owr_data); end
    checks++; if (bus.ogrant_spr !== 1'b0) begin errors++; $display("FAIL bg_spr_grant: got %b want 0", bus.ogrant_spr); end
    bus.ispr_wr = 1'b1; bus.ispr_addr = 8'd21; bus.ispr_data = 8'h55;
    step();
    idle_inputs();
    checks++; if (bus.owr !== 1'b0) begin errors++; $display("FAIL spr_ignored_in_bg: got %b want 0", bus.owr); end
  endtask

  task automatic test_layers();
    logic exp_wr0;
`ifdef LINE_RENDER_SCHED_TRANSP_EN
    exp_wr0 = 1'b0;
`else
    exp_wr0 = 1'b1;
`endif
    bus.ibg_done = 1'b1; bus.ibg_wr = 1'b1; bus.ibg_addr = 8'd11; bus.ibg_data = 8'h44;
    step();
    idle_inputs();
    checks++; if ({bus.ogrant_bg, bus.ogrant_spr} !== 2'b01) begin errors++; $display("FAIL spr_grant: got %b want 01", {bus.ogrant_bg, bus.ogrant_spr}); end
    checks++; if ({bus.owr, bus.owr_addr, bus.owr_data} !== {1'b1, 8'd11, 8'h44}) begin errors++; $display("FAIL bg_done_write: got wr=%b addr=%0d data=%0h want 1/11/44", bus.owr, bus.owr_addr, bus.owr_data); end
    bus.ispr_wr = 1'b1; bus.ispr_addr = 8'd1; bus.ispr_data = 8'h05;
    step();
    checks++; if ({bus.owr, bus.owr_addr, bus.owr_data} !== {1'b1, 8'd1, 8'h05}) begin errors++; $display("FAIL spr_write1: got wr=%b addr=%0d data=%0h want 1/1/5", bus.owr, bus.owr_addr, bus.owr_data); end
    bus.ispr_addr = 8'd2; bus.ispr_data = 8'h00;
    step();
    checks++; if (bus.owr !== exp_wr0) begin errors++; $display("FAIL spr_write_idx0: got wr=%b want %b", bus.owr, exp_wr0); end
    bus.ispr_addr = 8'd3; bus.ispr_data = 8'h07;
    step();
    checks++; if ({bus.owr, bus.owr_addr, bus.owr_data} !== {1'b1, 8'd3, 8'h07}) begin errors++; $display("FAIL spr_write3: got wr=%b addr=%0d data=%0h want 1/3/7", bus.owr, bus.owr_addr, bus.owr_data); end
    idle_inputs();
    bus.ispr_done = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.oline_ready !== 1'b1) begin errors++; $display("FAIL line_ready: got %b want 1", bus.oline_ready); end
    checks++; if ({bus.owr, bus.ogrant_bg, bus.ogrant_spr} !== 3'b000) begin errors++; $display("FAIL done_quiet: got %b want 000", {bus.owr, bus.ogrant_bg, bus.ogrant_spr}); end
    run(3);
    checks++; if (bus.oline_ready !== 1'b1) begin errors++; $display("FAIL ready_held: got %b want 1", bus.oline_ready); end
    pulse_start();
    checks++; if (bus.obank !== exp_bank) begin errors++; $display("FAIL done_swap_bank: got %b want %b", bus.obank, exp_bank); end
    checks++; if (bus.ooverrun !== 1'b0) begin errors++; $display("FAIL done_no_ovr: got %b want 0", bus.ooverrun); end
    checks++; if ({bus.owr, bus.owr_addr, bus.oline_ready} !== {1'b1, 8'd0, 1'b0}) begin errors++; $display("FAIL done_restart_clear: got wr=%b addr=%0d rdy=%b want 1/0/0", bus.owr, bus.owr_addr, bus.oline_ready); end
  endtask

  task automatic test_overrun_bg();
    run(256);
    checks++; if (bus.ogrant_bg !== 1'b1) begin errors++; $display("FAIL ovr_reach_bg: got %b want 1", bus.ogrant_bg); end
    pulse_start();
    checks++; if (bus.ooverrun !== 1'b1) begin errors++; $display("FAIL ovr_bg_pulse: got %b want 1", bus.ooverrun); end
    checks++; if (bus.obank !== exp_bank) begin errors++; $display("FAIL ovr_bg_bank: got %b want %b", bus.obank, exp_bank); end
    checks++; if ({bus.ogrant_bg, bus.owr, bus.owr_addr} !== {1'b0, 1'b1, 8'd0}) begin errors++; $display("FAIL ovr_bg_clear0: got gbg=%b wr=%b addr=%0d want 0/1/0", bus.ogrant_bg, bus.owr, bus.owr_addr); end
    step();
    checks++; if ({bus.ooverrun, bus.owr_addr} !== {1'b0, 8'd1}) begin errors++; $display("FAIL ovr_one_cycle: got ovr=%b addr=%0d want 0/1", bus.ooverrun, bus.owr_addr); end
  endtask

  task automatic test_done_with_start();
    run(255);
    bus.ibg_done = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.ogrant_spr !== 1'b1) begin errors++; $display("FAIL sim_reach_spr: got %b want 1", bus.ogrant_spr); end
    bus.ispr_done = 1'b1;
    pulse_start();
    idle_inputs();
    checks++; if (bus.ooverrun !== 1'b0) begin errors++; $display("FAIL sim_no_ovr: got %b want 0", bus.ooverrun); end
    checks++; if (bus.obank !== exp_bank) begin errors++; $display("FAIL sim_bank: got %b want %b", bus.obank, exp_bank); end
    checks++; if ({bus.ogrant_spr, bus.owr, bus.owr_addr, bus.oline_ready} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin errors++; $display("FAIL sim_clear: got gspr=%b wr=%b addr=%0d rdy=%b want 0/1/0/0", bus.ogrant_spr, bus.owr, bus.owr_addr, bus.oline_ready); end
  endtask

  task automatic test_start_wins();
    run(3);
    pulse_start();
    checks++; if (bus.ooverrun !== 1'b1) begin errors++; $display("FAIL ovr_clear: got %b want 1", bus.ooverrun); end
    run(256);
    bus.ibg_done = 1'b1; bus.ibg_wr = 1'b1; bus.ibg_addr = 8'd50; bus.ibg_data = 8'h09;
    pulse_start();
    idle_inputs();
    checks++; if (bus.ooverrun !== 1'b1) begin errors++; $display("FAIL start_wins_ovr: got %b want 1", bus.ooverrun); end
    checks++; if ({bus.ogrant_bg, bus.ogrant_spr, bus.owr_addr, bus.owr_data} !== {2'b00, 8'd0, 8'd0}) begin errors++; $display("FAIL start_wins_clear: got g=%b addr=%0d data=%0h want 00/0/0", {bus.ogrant_bg, bus.ogrant_spr}, bus.owr_addr, bus.owr_data); end
    checks++; if (bus.obank !== exp_bank) begin errors++; $display("FAIL start_wins_bank: got %b want %b", bus.obank, exp_bank); end
    run(256);
    step();
    checks++; if (bus.owr !== 1'b0) begin errors++; $display("FAIL dropped_write_leak: got %b want 0", bus.owr); end
  endtask

  task automatic test_reset_midline();
    pulse_start();
    checks++; if (bus.ooverrun !== 1'b1) begin errors++; $display("FAIL pre_reset_ovr: got %b want 1", bus.ooverrun); end
    irst_n = 1'b0;
    #1;
    exp_bank = 1'b0;
    checks++; if ({bus.obank, bus.ooverrun, bus.owr, bus.ogrant_bg, bus.oline_ready} !== 5'b0) begin errors++; $display("FAIL async_reset: got %b want 00000", {bus.obank, bus.ooverrun, bus.owr, bus.ogrant_bg, bus.oline_ready}); end
    run(2);
    irst_n = 1'b1;
    step();
    checks++; if ({bus.owr, bus.ogrant_bg} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got %b want 00", {bus.owr, bus.ogrant_bg}); end
    pulse_start();
    checks++; if ({bus.obank, bus.ooverrun} !== 2'b10) begin errors++; $display("FAIL post_reset_start: got bank/ovr=%b want 10", {bus.obank, bus.ooverrun}); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_clear();
    test_bg_write();
    test_layers();
    test_overrun_bg();
    test_done_with_start();
    test_start_wins();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
